spi_bus_owner_ctrl: RTL and testbench

- Sits directly downstream of the SPI access interrupt generator. Consumes its level interrupt (int_in) and arbitrates the shared configuration-flash SPI bus between the fabric (FPGA-side flash reader) and the MicroBlaze CPU.
- On an interrupt it drains any fabric transfer in progress, hands the bus mux to the CPU, and issues a one-cycle IRQ.
- Returns the bus to the fabric on CPU done, on interrupt withdrawal or on watchdog expiry.

---
 rtl/spi_bus_owner_ctrl.sv | 159 +++++++++++++++
 tb/tb_spi_bus_owner_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_owner_ctrl.sv
// Arbitrates the shared configuration-flash SPI bus between the fabric reader and the CPU.
// An interrupt drains the fabric, hands the bus to the CPU, then guards the return to the fabric.
module spi_bus_owner_ctrl #(
   parameter int WDOG_CYCLES  = 100000000,
   parameter int GUARD_CYCLES = 16,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             int_in,
   input  logic             cpu_done,
   input  logic             fpga_spi_req,
   input  logic             clr_flags,
   output logic             fpga_spi_gnt,
   output logic             spi_sel,
   output logic             irq,
   output logic             busy,
   output logic             timeout_flag,
   output logic             overrun_flag,
   output logic [CNT_W-1:0] irq_count,
   output logic [2:0]       state_dbg_o
);

   localparam int WDOG_W  = $clog2(WDOG_CYCLES);
   localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);
   localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FAB_OWN = 3'd1;
   localparam logic [2:0] ST_IRQ     = 3'd2;
   localparam logic [2:0] ST_CPU_OWN = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   logic [2:0]         state_q, state_d;
   logic               int_d1_q;
   logic               pend_q, pend_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;
   logic [GUARD_W-1:0] guard_q, guard_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;
   logic               overrun_q, overrun_d;

   logic int_rise;
   logic int_fall;
   logic wdog_hit;
   logic set_timeout;
   logic set_overrun;

   assign int_rise = int_in & ~int_d1_q;
   assign int_fall = ~int_in & int_d1_q;
   assign wdog_hit = (wdog_q == WDOG_LAST);

   // Fabric handshake: fpga_spi_req is a level held for the whole transfer; fpga_spi_gnt
   // rises only from IDLE and stays high until the fabric drops req, so it is never pre-empted.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      wdog_d      = wdog_q;
      guard_d     = guard_q;
      cnt_d       = cnt_q;
      set_timeout = 1'b0;
      set_overrun = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (int_rise) begin
               state_d = ST_IRQ;
            end else if (fpga_spi_req) begin
               state_d = ST_FAB_OWN;
            end
         end

         ST_FAB_OWN: begin
            if (int_rise) begin
               pend_d = 1'b1;
            end
            if (!fpga_spi_req) begin
               state_d = (pend_q | int_rise) ? ST_IRQ : ST_IDLE;
               pend_d  = 1'b0;
            end
         end

         ST_IRQ: begin
            cnt_d       = cnt_q + CNT_W'(1);
            wdog_d      = '0;
            set_overrun = int_rise;
            state_d     = ST_CPU_OWN;
         end

         ST_CPU_OWN: begin
            set_overrun = int_rise;
            set_timeout = wdog_hit;
            if (!wdog_hit) begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
            if (cpu_done | int_fall | wdog_hit) begin
               state_d = ST_RELEASE;
               guard_d = '0;
            end
         end

         ST_RELEASE: begin
            // Edges here are deferred rather than flagged: they become the next irq.
            if (int_rise) begin
               pend_d = 1'b1;
            end
            if (guard_q == GUARD_LAST) begin
               state_d = (pend_q | int_rise) ? ST_IRQ : ST_IDLE;
               pend_d  = 1'b0;
            end else begin
               guard_d = guard_q + GUARD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
         end
      endcase

      timeout_d = set_timeout | (timeout_q & ~clr_flags);
      overrun_d = set_overrun | (overrun_q & ~clr_flags);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         int_d1_q  <= 1'b0;
         pend_q    <= 1'b0;
         wdog_q    <= '0;
         guard_q   <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_d1_q  <= int_in;
         pend_q    <= pend_d;
         wdog_q    <= wdog_d;
         guard_q   <= guard_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
      end
   end

   // Outputs decode the state register directly so async reset drops the mux at once.
   assign fpga_spi_gnt = (state_q == ST_FAB_OWN);
   assign spi_sel      = (state_q == ST_IRQ) || (state_q == ST_CPU_OWN);
   assign irq          = (state_q == ST_IRQ);
   assign busy         = (state_q != ST_IDLE);
   assign timeout_flag = timeout_q;
   assign overrun_flag = overrun_q;
   assign irq_count    = cnt_q;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_spi_bus_owner_ctrl.sv
// Bench for spi_bus_owner_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a bus-holder model built from the ownership rules.
module tb_spi_bus_owner_ctrl;

   localparam int WDOG  = 50;
   localparam int GUARD = 4;
   localparam int CNT_W = 4;

   localparam int H_NONE  = 0;
   localparam int H_FAB   = 1;
   localparam int H_IRQ   = 2;
   localparam int H_CPU   = 3;
   localparam int H_GUARD = 4;

   logic             clk;
   logic             rst;
   logic             int_in;
   logic             cpu_done;
   logic             fpga_spi_req;
   logic             clr_flags;
   logic             fpga_spi_gnt;
   logic             spi_sel;
   logic             irq;
   logic             busy;
   logic             timeout_flag;
   logic             overrun_flag;
   logic [CNT_W-1:0] irq_count;
   logic [2:0]       state_dbg;

   int n_checks;
   int n_fail;

   // reference model: who holds the bus and for how long
   int m_holder;
   int m_age;
   int m_guard_left;
   int m_count;
   bit m_pend;
   bit m_to;
   bit m_ov;
   bit m_int_d;

   spi_bus_owner_ctrl #(
      .WDOG_CYCLES (WDOG),
      .GUARD_CYCLES(GUARD),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .int_in      (int_in),
      .cpu_done    (cpu_done),
      .fpga_spi_req(fpga_spi_req),
      .clr_flags   (clr_flags),
      .fpga_spi_gnt(fpga_spi_gnt),
      .spi_sel     (spi_sel),
      .irq         (irq),
      .busy        (busy),
      .timeout_flag(timeout_flag),
      .overrun_flag(overrun_flag),
      .irq_count   (irq_count),
      .state_dbg_o (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_holder     = H_NONE;
      m_age        = 0;
      m_guard_left = 0;
      m_count      = 0;
      m_pend       = 1'b0;
      m_to         = 1'b0;
      m_ov         = 1'b0;
      m_int_d      = 1'b0;
   endtask

   task automatic model_step();
      bit rise;
      bit fall;
      bit expire;
      bit set_to;
      bit set_ov;
      rise   = int_in && !m_int_d;
      fall   = !int_in && m_int_d;
      set_to = 1'b0;
      set_ov = 1'b0;
      case (m_holder)
         H_NONE: begin
            if (rise) m_holder = H_IRQ;
            else if (fpga_spi_req) m_holder = H_FAB;
         end
         H_FAB: begin
            if (rise) m_pend = 1'b1;
            if (!fpga_spi_req) begin
               m_holder = m_pend ? H_IRQ : H_NONE;
               m_pend   = 1'b0;
            end
         end
         H_IRQ: begin
            m_count  = (m_count + 1) % (1 << CNT_W);
            m_age    = 0;
            set_ov   = rise;
            m_holder = H_CPU;
         end
         H_CPU: begin
            set_ov = rise;
            expire = (m_age == WDOG - 1);
            set_to = expire;
            if (cpu_done || fall || expire) begin
               m_holder     = H_GUARD;
               m_guard_left = GUARD;
            end else begin
               m_age++;
            end
         end
         default: begin
            if (rise) m_pend = 1'b1;
            m_guard_left--;
            if (m_guard_left == 0) begin
               m_holder = m_pend ? H_IRQ : H_NONE;
               m_pend   = 1'b0;
            end
         end
      endcase
      m_to    = set_to || (m_to && !clr_flags);
      m_ov    = set_ov || (m_ov && !clr_flags);
      m_int_d = int_in;
   endtask

   task automatic compare_all();
      check_eq("gnt",     32'(fpga_spi_gnt), 32'(m_holder == H_FAB));
      check_eq("spi_sel", 32'(spi_sel),      32'(m_holder == H_IRQ || m_holder == H_CPU));
      check_eq("irq",     32'(irq),          32'(m_holder == H_IRQ));
      check_eq("busy",    32'(busy),         32'(m_holder != H_NONE));
      check_eq("timeout", 32'(timeout_flag), 32'(m_to));
      check_eq("overrun", 32'(overrun_flag), 32'(m_ov));
      check_eq("count",   32'(irq_count),    32'(m_count));
   endtask

   // inputs change at negedge; DUT and model both advance on posedge
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_done();
      cpu_done = 1'b1;
      step();
      cpu_done = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
   endtask

   // reset asserted between edges must clear outputs without a clock
   task automatic async_reset(input bit keep_req);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_eq("async_sel",   32'(spi_sel),   32'(0));
      check_eq("async_gnt",   32'(fpga_spi_gnt), 32'(0));
      check_eq("async_busy",  32'(busy),      32'(0));
      check_eq("async_count", 32'(irq_count), 32'(0));
      int_in       = 1'b0;
      cpu_done     = 1'b0;
      clr_flags    = 1'b0;
      fpga_spi_req = keep_req;
      @(posedge clk);
      @(negedge clk);
      compare_all();
      rst = 1'b0;
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      int_in       = 1'b0;
      cpu_done     = 1'b0;
      fpga_spi_req = 1'b0;
      clr_flags    = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      run(3);

      // idle interrupt, cpu_done release
      int_in = 1'b1;
      step();
      check_eq("idle_irq", 32'(irq), 32'(1));
      run(8);
      pulse_done();
      check_eq("done_sel_low", 32'(spi_sel), 32'(0));
      run(GUARD + 2);
      check_eq("idle_cnt", 32'(irq_count), 32'(1));
      int_in = 1'b0;
      run(2);

      // fabric drain: interrupt waits for the fabric to finish
      fpga_spi_req = 1'b1;
      run(3);
      int_in = 1'b1;
      run(22);
      check_eq("drain_gnt", 32'(fpga_spi_gnt), 32'(1));
      fpga_spi_req = 1'b0;
      step();
      check_eq("drain_irq", 32'(irq), 32'(1));
      run(3);
      pulse_done();
      run(GUARD + 2);
      int_in = 1'b0;
      run(2);

      // watchdog expiry
      int_in = 1'b1;
      run(WDOG + 8);
      check_eq("wdog_to", 32'(timeout_flag), 32'(1));
      pulse_clr();
      check_eq("wdog_clr", 32'(timeout_flag), 32'(0));
      int_in = 1'b0;
      run(3);

      // interrupt and fabric request in the same idle cycle
      int_in       = 1'b1;
      fpga_spi_req = 1'b1;
      step();
      check_eq("simul_gnt", 32'(fpga_spi_gnt), 32'(0));
      run(3);
      pulse_done();
      run(GUARD + 2);
      check_eq("simul_late_gnt", 32'(fpga_spi_gnt), 32'(1));
      fpga_spi_req = 1'b0;
      int_in       = 1'b0;
      run(3);

      // overrun in CPU_OWN, then an edge pended during RELEASE
      int_in = 1'b1;
      step();
      int_in = 1'b0;
      step();
      int_in = 1'b1;
      step();
      check_eq("overrun", 32'(overrun_flag), 32'(1));
      run(2);
      pulse_done();
      int_in = 1'b0;
      step();
      int_in = 1'b1;
      run(GUARD + 2);
      check_eq("pend_cnt", 32'(irq_count), 32'(6));
      int_in = 1'b0;
      run(GUARD + 3);
      pulse_clr();

      // reset in CPU_OWN, fabric granted right after release
      int_in = 1'b1;
      run(5);
      async_reset(1'b1);
      step();
      check_eq("post_rst_gnt", 32'(fpga_spi_gnt), 32'(1));
      fpga_spi_req = 1'b0;
      run(2);

      // counter wrap
      for (int k = 0; k < 17; k++) begin
         int_in = 1'b1;
         run(3);
         pulse_done();
         int_in = 1'b0;
         run(GUARD + 1);
      end
      check_eq("wrap", 32'(irq_count), 32'(1));

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 59) == 0) int_in = ~int_in;
         if (!fpga_spi_req && $urandom_range(0, 9) == 0) fpga_spi_req = 1'b1;
         else if (fpga_spi_req && $urandom_range(0, 14) == 0) fpga_spi_req = 1'b0;
         cpu_done  = ($urandom_range(0, 69) == 0);
         clr_flags = ($urandom_range(0, 49) == 0);
         if (c == 1200 || c == 2400) async_reset(1'b0);
         else step();
      end
      cpu_done  = 1'b0;
      clr_flags = 1'b0;
      run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
